// File: rtl/obi_mem_arbiter_if.sv
// Request/response bundle for one OBI-style req/gnt/rvalid memory port.
// The arbiter takes instr and data as slaves and drives mem as master.
interface obi_mem_arbiter_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/obi_mem_arbiter.sv
// Shares one memory port between instruction fetch and LSU, tracking the
// source of every accepted request so in-order responses route back correctly.
module obi_mem_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int DATA_PRIORITY   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  obi_mem_arbiter_if.slave      instr,
  obi_mem_arbiter_if.slave      data,
  obi_mem_arbiter_if.master     mem,
  output logic                  protocol_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST  = PW'(MAX_OUTSTANDING - 1);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]    state_r;
  logic          hold_src_r;
  logic          last_grant_r;
  logic          src_q_r [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          protocol_err_r;

  logic sel_s;
  logic full_s;
  logic empty_s;
  logic accept_s;
  logic pop_s;
  logic head_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? {PW{1'b0}} : p + PW'(1);
  endfunction

  // full is registered so a same-cycle pop never frees a slot for a push
  assign full_s   = (count_r == COUNT_MAX);
  assign empty_s  = (count_r == {CW{1'b0}});
  assign accept_s = mem.req & mem.gnt;
  assign pop_s    = mem.rvalid & ~empty_s;
  assign head_s   = src_q_r[rd_ptr_r];

  // Source selection: frozen while a request waits for its grant
  always_comb begin
    sel_s = 1'b0;
    if (state_r == ST_HOLD) begin
      sel_s = hold_src_r;
    end else if (instr.req && data.req) begin
      sel_s = (DATA_PRIORITY != 0) ? 1'b1 : ~last_grant_r;
    end else if (data.req) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Memory request mux; idle fields stay zero so an idle port reads all-zero
  always_comb begin
    mem.req   = (instr.req | data.req) & ~full_s;
    mem.we    = 1'b0;
    mem.be    = 4'h0;
    mem.addr  = 32'h0;
    mem.wdata = 32'h0;
    if (sel_s) begin
      mem.we    = data.we;
      mem.be    = data.be;
      mem.addr  = data.addr;
      mem.wdata = data.wdata;
    end else if (instr.req) begin
      mem.be    = 4'hF;
      mem.addr  = instr.addr;
    end else begin
      mem.be    = 4'h0;
    end
  end

  assign instr.gnt    = accept_s & ~sel_s;
  assign data.gnt     = accept_s & sel_s;
  assign instr.rvalid = pop_s & ~head_s;
  assign instr.err    = pop_s & ~head_s & mem.err;
  assign instr.rdata  = mem.rdata;
  assign data.rvalid  = pop_s & head_s;
  assign data.err     = pop_s & head_s & mem.err;
  assign data.rdata   = mem.rdata;
  assign protocol_err = protocol_err_r;

  // Arbiter FSM plus round-robin history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_ARB;
      hold_src_r   <= 1'b0;
      last_grant_r <= 1'b0;
    end else begin
      case (state_r)
        ST_ARB: begin
          if (mem.req && !mem.gnt) begin
            state_r    <= ST_HOLD;
            hold_src_r <= sel_s;
          end
        end
        ST_HOLD: begin
          if (mem.gnt) state_r <= ST_ARB;
        end
        default: state_r <= ST_ARB;
      endcase
      if (accept_s) last_grant_r <= sel_s;
    end
  end

  // In-order source tracker and sticky protocol error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) src_q_r[i] <= 1'b0;
      wr_ptr_r       <= {PW{1'b0}};
      rd_ptr_r       <= {PW{1'b0}};
      count_r        <= {CW{1'b0}};
      protocol_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        src_q_r[wr_ptr_r] <= sel_s;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
      case ({accept_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (mem.rvalid && empty_s) protocol_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Scoreboard bench: a data-priority instance runs the scripted scenarios,
// a round-robin instance runs the alternating-conflict case.
module tb_obi_mem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic perr_dp, perr_rr;

  always #5 clk = ~clk;

  obi_mem_arbiter_if pi();
  obi_mem_arbiter_if pd();
  obi_mem_arbiter_if pm();
  obi_mem_arbiter_if ri();
  obi_mem_arbiter_if rd();
  obi_mem_arbiter_if rm();

  obi_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(1)) dut_dp (
    .clk(clk), .reset_n(reset_n), .instr(pi), .data(pd), .mem(pm), .protocol_err(perr_dp)
  );

  obi_mem_arbiter #(.MAX_OUTSTANDING(2), .DATA_PRIORITY(0)) dut_rr (
    .clk(clk), .reset_n(reset_n), .instr(ri), .data(rd), .mem(rm), .protocol_err(perr_rr)
  );

  typedef struct packed { logic src; logic [31:0] addr; } acc_t;
  typedef struct packed { logic src; logic [31:0] rdata; logic err; } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  acc_t a_m;
  rsp_t r_m;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Scoreboard monitor for the data-priority instance
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (pm.req && pm.gnt) begin
        check_val("acc_queue", 32'(exp_acc.size() > 0), 32'd1);
        if (exp_acc.size() > 0) begin
          a_m = exp_acc.pop_front();
          check_val("acc_data_gnt", {31'd0, pd.gnt}, {31'd0, a_m.src});
          check_val("acc_instr_gnt", {31'd0, pi.gnt}, {31'd0, ~a_m.src});
          check_val("acc_addr", pm.addr, a_m.addr);
        end
      end
      if (pi.rvalid || pd.rvalid) begin
        check_val("rsp_queue", 32'(exp_rsp.size() > 0), 32'd1);
        if (exp_rsp.size() > 0) begin
          r_m = exp_rsp.pop_front();
          check_val("rsp_src", {31'd0, pd.rvalid}, {31'd0, r_m.src});
          check_val("rsp_dual", {31'd0, pi.rvalid & pd.rvalid}, 32'd0);
          check_val("rsp_rdata", r_m.src ? pd.rdata : pi.rdata, r_m.rdata);
          check_val("rsp_err", {31'd0, r_m.src ? pd.err : pi.err}, {31'd0, r_m.err});
        end
      end
    end
  end

  task automatic cyc(input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [3:0] db,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic g, input logic rv, input logic [31:0] rdt, input logic e);
    @(posedge clk); #1;
    pi.req = ir; pi.addr = ia;
    pd.req = dr; pd.we = dw; pd.be = db; pd.addr = da; pd.wdata = dwd;
    pm.gnt = g; pm.rvalid = rv; pm.rdata = rdt; pm.err = e;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rsp(input logic [31:0] rdt, input logic e);
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, rdt, e);
  endtask

  initial begin
    reset_n = 1'b0;
    pi.req = 1'b0; pi.we = 1'b0; pi.be = 4'h0; pi.addr = 32'h0; pi.wdata = 32'h0;
    pd.req = 1'b0; pd.we = 1'b0; pd.be = 4'h0; pd.addr = 32'h0; pd.wdata = 32'h0;
    pm.gnt = 1'b0; pm.rvalid = 1'b0; pm.rdata = 32'h0; pm.err = 1'b0;
    ri.req = 1'b0; ri.we = 1'b0; ri.be = 4'h0; ri.addr = 32'h0; ri.wdata = 32'h0;
    rd.req = 1'b0; rd.we = 1'b0; rd.be = 4'h0; rd.addr = 32'h0; rd.wdata = 32'h0;
    rm.gnt = 1'b0; rm.rvalid = 1'b0; rm.rdata = 32'h0; rm.err = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    // reset state, all inputs low
    check_val("rst_mem_req", {31'd0, pm.req}, 32'd0);
    check_val("rst_mem_we", {31'd0, pm.we}, 32'd0);
    check_val("rst_mem_be", {28'd0, pm.be}, 32'd0);
    check_val("rst_mem_addr", pm.addr, 32'd0);
    check_val("rst_mem_wdata", pm.wdata, 32'd0);
    check_val("rst_gnts", {30'd0, pi.gnt, pd.gnt}, 32'd0);
    check_val("rst_valids", {28'd0, pi.rvalid, pd.rvalid, pi.err, pd.err}, 32'd0);
    check_val("rst_rdata", pi.rdata | pd.rdata, 32'd0);
    check_val("rst_perr", {31'd0, perr_dp}, 32'd0);
    check_val("rst_count", 32'(dut_dp.count_r), 32'd0);

    // instruction-only stream
    exp_acc.push_back('{1'b0, 32'h0});
    exp_acc.push_back('{1'b0, 32'h4});
    exp_acc.push_back('{1'b0, 32'h8});
    exp_rsp.push_back('{1'b0, 32'h00000013, 1'b0});
    exp_rsp.push_back('{1'b0, 32'h00100093, 1'b0});
    exp_rsp.push_back('{1'b0, 32'h00200113, 1'b0});
    cyc(1'b1, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00000013, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00100093, 1'b0);
    rsp(32'h00200113, 1'b0);
    idle();

    // conflict with data priority: data wins every cycle
    exp_acc.push_back('{1'b1, 32'h10});
    exp_acc.push_back('{1'b1, 32'h14});
    exp_acc.push_back('{1'b1, 32'h18});
    exp_rsp.push_back('{1'b1, 32'hD0000001, 1'b0});
    exp_rsp.push_back('{1'b1, 32'hD0000002, 1'b0});
    exp_rsp.push_back('{1'b1, 32'hD0000003, 1'b0});
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 1'b1, 1'b1, 32'hD0000001, 1'b0);
    cyc(1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h18, 32'h0, 1'b1, 1'b1, 32'hD0000002, 1'b0);
    rsp(32'hD0000003, 1'b0);
    idle();

    // stall: instruction held while data arrives, data goes next
    exp_acc.push_back('{1'b0, 32'h80});
    exp_acc.push_back('{1'b1, 32'h3000});
    exp_rsp.push_back('{1'b0, 32'h80808080, 1'b0});
    exp_rsp.push_back('{1'b1, 32'h0, 1'b0});
    cyc(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    check_val("stall0_addr", pm.addr, 32'h80);
    for (int k = 1; k < 3; k++) begin
      cyc(1'b1, 32'h80, 1'b1, 1'b1, 4'hF, 32'h3000, 32'h77, 1'b0, 1'b0, 32'h0, 1'b0);
      check_val("stall_addr", pm.addr, 32'h80);
      check_val("stall_we", {31'd0, pm.we}, 32'd0);
    end
    cyc(1'b1, 32'h80, 1'b1, 1'b1, 4'hF, 32'h3000, 32'h77, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("stall_gnt_we", {31'd0, pm.we}, 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h3000, 32'h77, 1'b1, 1'b1, 32'h80808080, 1'b0);
    check_val("stall_data_we", {31'd0, pm.we}, 32'd1);
    rsp(32'h0, 1'b0);
    idle();

    // tracker full: no accept until a response frees a slot
    exp_acc.push_back('{1'b0, 32'h200});
    exp_acc.push_back('{1'b1, 32'h204});
    exp_acc.push_back('{1'b0, 32'h208});
    exp_rsp.push_back('{1'b0, 32'hAAAA, 1'b0});
    exp_rsp.push_back('{1'b1, 32'hBBBB, 1'b0});
    exp_rsp.push_back('{1'b0, 32'hCCCC, 1'b0});
    cyc(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h204, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h208, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("full_req", {31'd0, pm.req}, 32'd0);
    check_val("full_gnts", {30'd0, pi.gnt, pd.gnt}, 32'd0);
    cyc(1'b1, 32'h208, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hAAAA, 1'b0);
    check_val("full_pop_req", {31'd0, pm.req}, 32'd0);
    cyc(1'b1, 32'h208, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hBBBB, 1'b0);
    check_val("full_reenable", {31'd0, pm.req}, 32'd1);
    rsp(32'hCCCC, 1'b0);
    idle();

    // mixed routing with error on the data write
    exp_acc.push_back('{1'b0, 32'h100});
    exp_acc.push_back('{1'b1, 32'h2000});
    exp_rsp.push_back('{1'b0, 32'h55, 1'b0});
    exp_rsp.push_back('{1'b1, 32'h0, 1'b1});
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 4'h0, 32'h9999, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("ifetch_we", {31'd0, pm.we}, 32'd0);
    check_val("ifetch_be", {28'd0, pm.be}, 32'hF);
    check_val("ifetch_wdata", pm.wdata, 32'd0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h2000, 32'h1234, 1'b1, 1'b0, 32'h0, 1'b0);
    check_val("wr_we", {31'd0, pm.we}, 32'd1);
    check_val("wr_be", {28'd0, pm.be}, 32'h3);
    check_val("wr_wdata", pm.wdata, 32'h1234);
    rsp(32'h55, 1'b0);
    rsp(32'h0, 1'b1);
    check_val("mixed_instr_err", {31'd0, pi.err}, 32'd0);
    idle();

    // round-robin instance: alternating D, I, D, I
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      ri.req = (k < 4); ri.addr = 32'h40;
      rd.req = (k < 4); rd.addr = 32'h10;
      rm.gnt = (k < 4); rm.rvalid = (k > 0); rm.rdata = 32'(k);
      @(negedge clk);
      if (k < 4) begin
        check_val("rr_data_gnt", {31'd0, rd.gnt}, {31'd0, (k % 2) == 0});
        check_val("rr_instr_gnt", {31'd0, ri.gnt}, {31'd0, (k % 2) == 1});
      end
      if (k > 0) begin
        check_val("rr_data_rvalid", {31'd0, rd.rvalid}, {31'd0, ((k - 1) % 2) == 0});
        check_val("rr_instr_rvalid", {31'd0, ri.rvalid}, {31'd0, ((k - 1) % 2) == 1});
      end
    end
    @(posedge clk); #1;
    rm.rvalid = 1'b0;
    @(negedge clk);

    // spurious response with empty tracker
    check_val("perr_clean", {31'd0, perr_dp}, 32'd0);
    rsp(32'h1234, 1'b0);
    check_val("spur_valids", {30'd0, pi.rvalid, pd.rvalid}, 32'd0);
    idle();
    check_val("spur_perr", {31'd0, perr_dp}, 32'd1);
    idle();
    check_val("spur_perr_held", {31'd0, perr_dp}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_val("rst_perr_clr", {31'd0, perr_dp}, 32'd0);
    check_val("rst_count_clr", 32'(dut_dp.count_r), 32'd0);
    check_val("rr_perr", {31'd0, perr_rr}, 32'd0);

    check_val("acc_left", 32'(exp_acc.size()), 32'd0);
    check_val("rsp_left", 32'(exp_rsp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-to-one arbiter that shares a single req/gnt/rvalid program/data memory port between the fetch unit's instruction interface and the load-store unit's data interface. It sits between `if_stage`/LSU and the memory.
- It selects one requester per cycle and holds that selection stable until the memory grants it.
- It records the source of every accepted transaction in an in-order tracker.
- It routes each response back to the requester that issued it.

## Interface
Parameters:
- MAX_OUTSTANDING, default 2: maximum accepted-but-unanswered transactions. Range 1..8.
- DATA_PRIORITY, default 1: 1 = data port wins every conflict; 0 = round-robin.

Ports:
- clk  input  1  clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- instr_req  input  1  fetch request
- instr_addr  input  32  fetch address (word aligned)
- instr_gnt  output  1  fetch request accepted
- instr_valid  output  1  fetch response valid
- instr_rdata  output  32  fetch response data
- instr_err  output  1  fetch response error
- data_req  input  1  LSU request
- data_we  input  1  1 = write
- data_be  input  4  byte enables
- data_addr  input  32  LSU address
- data_wdata  input  32  write data
- data_gnt  output  1  LSU request accepted
- data_rvalid  output  1  LSU response valid (reads and writes)
- data_rdata  output  32  LSU read data
- data_err  output  1  LSU response error
- mem_req, mem_we  output  1  memory request, write enable
- mem_addr, mem_wdata  output  32  memory address, write data
- mem_be  output  4  memory byte enables
- mem_gnt, mem_rvalid, mem_err  input  1  memory grant, response valid, response error
- mem_rdata  input  32  memory response data
- protocol_err  output  1  sticky: response arrived with empty tracker

## Operation
- Arbiter FSM, states ARB and HOLD.
  - ARB: selection is combinational from the current requests.
  - ARB → HOLD when mem_req=1 and mem_gnt=0.
  - HOLD: selection is frozen to the registered source; a newly arriving request on the other port is ignored.
  - HOLD → ARB on mem_gnt=1.
- Selection rules:
  - Only one port requesting: that port is selected.
  - Both requesting, DATA_PRIORITY=1: data is selected.
  - Both requesting, DATA_PRIORITY=0: the port not granted last is selected. last_grant updates on every accepted transaction.
- mem_req = (instr_req | data_req) & ~tracker_full. All mem_* fields are muxed from the selected port.
  - For instruction requests: mem_we=0, mem_be=4'hF, mem_wdata=0.
- Accept = mem_req & mem_gnt. Only the selected port's gnt is raised, equal to mem_gnt. The other port's gnt is 0.
- Tracker: FIFO of 1-bit source IDs (0=instr, 1=data), depth MAX_OUTSTANDING, with a count of width $clog2(MAX_OUTSTANDING+1).
  - Push on accept; pop on mem_rvalid.
  - Push and pop in the same cycle leave the count unchanged. When full, a same-cycle pop does NOT enable a push (mem_req uses the registered full).
- Response routing:
  - Head=instr: instr_valid = mem_rvalid; instr_rdata and instr_err come from memory.
  - Head=data: data_rvalid = mem_rvalid; data_rdata and data_err come from memory.
  - Both rdata outputs always carry mem_rdata. Valid and err outputs are gated by head.
- Responses return in order. Requesters must accept a response in any cycle; there is no backpressure.
- mem_rvalid with empty tracker: dropped (no valid on either port), protocol_err set to 1 and held until reset.
- Requesters that flush (`if_stage` fifo_clear) still receive their pending responses. The arbiter never discards a tracked entry.

## Timing
- Request path is combinational: req → mem_req and mem_gnt → port gnt in the same cycle. Response path is combinational: mem_rvalid → port valid.
- Minimum response latency is 1 cycle after accept, set by the memory. Back-to-back accepts are allowed every cycle until the tracker is full.
- Reset values:
  - FSM=ARB, tracker empty (count 0), last_grant=instr (data wins the first round-robin conflict), protocol_err=0.
  - With all inputs low, every output is 0.
- Reset mid-operation empties the tracker at once. Responses arriving after reset release set protocol_err; the environment must quiesce memory on reset.

## Test plan
- Instr-only stream: 3 fetches at 0x0, 0x4, 0x8, mem_gnt=1, rvalid 1 cycle later with rdata 0x00000013, 0x00100093, 0x00200113 → instr_valid pulses carry those values in order; data_rvalid stays 0.
- Conflict, DATA_PRIORITY=0, both ports requesting continuously, mem_gnt=1, immediate responses → accept order is D, I, D, I. With DATA_PRIORITY=1 → D, D, D and instr_gnt stays 0.
- Stall hold: instr selected, mem_gnt=0 for 3 cycles, data_req rises in cycle 2 → mem_addr stays at the instr address and mem_we=0 until the grant; data is accepted on the next cycle.
- Tracker full, MAX_OUTSTANDING=2: two accepts, no rvalid → mem_req=0 and both gnts are 0. rvalid in cycle N re-enables mem_req in cycle N+1; the first response routes to the first source.
- Mixed routing: accept I@0x100 then D write@0x2000, be=4'b0011. Responses: first rvalid with err=0, second with err=1 → instr_valid then data_rvalid with data_err=1; instr_err stays 0.
- Spurious response: mem_rvalid=1 with an empty tracker → no port valid, protocol_err=1 and held. Assert reset_n=0 → protocol_err=0 and count=0.
